// File: rtl/pipeline_ctrl_if.sv
// Purpose : hazard/stall control bundle between the datapath and pipeline_ctrl.
// Latency : none, wires only; pipeline_ctrl drives the controls combinationally from its inputs.
// Backpressure: stalls and bubbles are carried on the _en/_flush controls; there is no handshake.
//
// Ports (slave view = pipeline_ctrl):
//   in : ihit, dhit, mem_dREN, mem_dWEN, idex_MemRead, idex_Rt, ifid_Rs, ifid_Rt,
//        mem_brtaken, mem_halt
//   out: pc_en, {ifid,idex,exmem,memwb}_en, {ifid,idex,exmem,memwb}_flush,
//        halt_o, stall_cnt
interface pipeline_ctrl_if;
    // Datapath status toward the controller
    logic        ihit;
    logic        dhit;
    logic        mem_dREN;
    logic        mem_dWEN;
    logic        idex_MemRead;
    logic [4:0]  idex_Rt;
    logic [4:0]  ifid_Rs;
    logic [4:0]  ifid_Rt;
    logic        mem_brtaken;
    logic        mem_halt;

    // Controller decisions toward the datapath
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        memwb_flush;
    logic        halt_o;
    logic [31:0] stall_cnt;

    // Datapath side: supplies the status and consumes the controls.
    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, idex_MemRead,
               idex_Rt, ifid_Rs, ifid_Rt, mem_brtaken, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt_o, stall_cnt
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, idex_MemRead,
               idex_Rt, ifid_Rs, ifid_Rt, mem_brtaken, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt_o, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Purpose : 5-stage pipeline hazard controller: PC/latch enables, bubbles, halt, stall counter.
// Latency : enables/flushes are combinational in the same cycle; state and stall_cnt are registered.
// Backpressure: a data miss freezes PC..EX/MEM and bubbles MEM/WB; a load-use hazard or fetch miss
//           holds the front end. HALT freezes every latch until nRST.
//
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset (state -> RUN, stall_cnt -> 0)
//   pif  - pipeline_ctrl_if.slave (hazard status in, pipeline controls/halt/stall_cnt out)
module pipeline_ctrl (
    input  logic           CLK,
    input  logic           nRST,
    pipeline_ctrl_if.slave pif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] stall_cnt_q;

    logic dmiss;
    logic loaduse;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
    logic halt_o;

    // Hazard detection. A load into $zero never creates a dependency.
    assign dmiss   = (pif.mem_dREN | pif.mem_dWEN) & ~pif.dhit;
    assign loaduse = pif.idex_MemRead & (pif.idex_Rt != 5'd0) &
                     ((pif.idex_Rt == pif.ifid_Rs) | (pif.idex_Rt == pif.ifid_Rt));

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. RUN and DWAIT share one decode. DWAIT only records
    // that a miss is outstanding; once dhit arrives dmiss drops and the
    // controller falls back to RUN.
    always_comb begin
        next_state = state;
        case (state)
            RUN, DWAIT: begin
                if (pif.mem_halt) begin
                    next_state = HALT;
                end else if (dmiss) begin
                    next_state = DWAIT;
                end else begin
                    next_state = RUN;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    // Output logic. Flushes take precedence over the matching enable in the
    // datapath, so an enable may be left high alongside its flush.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halt_o      = 1'b0;

        case (state)
            HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halt_o   = 1'b1;
            end
            default: begin
                if (pif.mem_halt) begin
                    // Drain: freeze everything and keep the instructions behind
                    // the halt from committing.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_en    = 1'b0;
                    memwb_flush = 1'b1;
                end else if (dmiss) begin
                    // Hold PC..EX/MEM so the memory op is retried. Bubble WB so a
                    // stale result is not written twice.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                end else if (pif.mem_brtaken) begin
                    // Redirect fetch and squash the three younger instructions.
                    // PC loads even on an ifetch miss because the target
                    // replaces the fetch that is in flight.
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (loaduse) begin
                    // Hold the dependent instruction in ID for one cycle and let
                    // the load move ahead. The bubble in EX clears idex_MemRead,
                    // so the hazard cannot repeat for the same load.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (!pif.ihit) begin
                    // Fetch miss: hold PC and insert a bubble behind the fetch.
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        endcase
    end

    // Stall counter: counts cycles in which PC is held outside HALT, and
    // saturates at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= 32'd0;
        end else if ((state != HALT) && !pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign pif.pc_en       = pc_en;
    assign pif.ifid_en     = ifid_en;
    assign pif.idex_en     = idex_en;
    assign pif.exmem_en    = exmem_en;
    assign pif.memwb_en    = memwb_en;
    assign pif.ifid_flush  = ifid_flush;
    assign pif.idex_flush  = idex_flush;
    assign pif.exmem_flush = exmem_flush;
    assign pif.memwb_flush = memwb_flush;
    assign pif.halt_o      = halt_o;
    assign pif.stall_cnt   = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 CLK  in  1  clock; all state changes on its rising edge.
REQ-002 nRST  in  1  reset, asynchronous, active-low.
REQ-003 ihit  in  1  instruction fetch for current PC completes this cycle.
REQ-004 dhit  in  1  data access requested by MEM stage completes this cycle.
REQ-005 mem_dREN, mem_dWEN  in  1 each  MEM-stage data read/write request.
REQ-006 idex_MemRead  in  1  EX-stage instruction is a load.
REQ-007 idex_Rt  in  5  load destination register in EX stage.
REQ-008 ifid_Rs, ifid_Rt  in  5 each  source registers of ID-stage instruction.
REQ-009 mem_brtaken  in  1  MEM-stage branch/jump resolved taken.
REQ-010 mem_halt  in  1  halt instruction reached MEM stage.
REQ-011 pc_en  out  1  PC loads next value.
REQ-012 ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch captures its inputs.
REQ-013 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads all-zero bubble; overrides matching _en.
REQ-014 halt_o  out  1  processor halted, sticky.
REQ-015 stall_cnt  out  32  count of cycles with pc_en=0 outside HALT.

Function
REQ-016 FSM states RUN, DWAIT, HALT; outputs combinational from state and inputs; stall_cnt and state registered.
REQ-017 dmiss = (mem_dREN|mem_dWEN) & ~dhit; loaduse = idex_MemRead & (idex_Rt!=0) & (idex_Rt==ifid_Rs | idex_Rt==ifid_Rt).
REQ-018 RUN default (no event): all _en=1, all _flush=0.
REQ-019 Priority in RUN/DWAIT, highest first: mem_halt, dmiss, mem_brtaken, loaduse, ~ihit.
REQ-020 mem_halt (any non-HALT state): all _en=0, memwb_flush=1, next state HALT.
REQ-021 dmiss: pc_en, ifid_en, idex_en, exmem_en =0; memwb_flush=1; next state DWAIT.
REQ-022 DWAIT with dhit=1: outputs as RUN evaluated on remaining priorities (brtaken/loaduse/ihit), next state RUN; with dhit=0: per REQ-021, stay DWAIT.
REQ-023 mem_brtaken: pc_en=1 regardless of ihit; ifid_flush, idex_flush, exmem_flush =1; memwb_en=1.
REQ-024 loaduse: pc_en=0, ifid_en=0, idex_flush=1; exmem_en, memwb_en=1; exactly one bubble per load (loaduse false next cycle by construction).
REQ-025 ~ihit: pc_en=0, ifid_flush=1; idex_en, exmem_en, memwb_en=1.
REQ-026 HALT: all _en=0, all _flush=0, halt_o=1; exits only via nRST.
REQ-027 stall_cnt increments by 1 each cycle pc_en=0 in RUN/DWAIT; saturates at 32'hFFFFFFFF (no wrap).
REQ-028 halt_o=1 in HALT only; 0 otherwise.

Reset
REQ-029 nRST low: state=RUN, stall_cnt=0 immediately, independent of CLK; outputs then follow RUN decode.
REQ-030 nRST asserted mid-DWAIT or HALT: returns to RUN, counter cleared; first edge after release follows REQ-018..025.

Verification
REQ-031 mem_dREN=1, dhit=0 for 3 cycles then 1 -> 3 cycles pc_en=0, memwb_flush=1, state DWAIT; dhit cycle all _en=1; stall_cnt=3.
REQ-032 idex_MemRead=1, idex_Rt=5, ifid_Rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 one cycle; stall_cnt=1; idex_Rt=0 variant -> no stall.
REQ-033 mem_brtaken=1 with loaduse=1 and ihit=0 -> pc_en=1, ifid/idex/exmem_flush=1, stall_cnt unchanged.
REQ-034 mem_halt=1 with dmiss=1 -> HALT next edge, halt_o=1 held 10 cycles despite input toggling, stall_cnt frozen.
REQ-035 Force stall_cnt near 32'hFFFFFFFE, ihit=0 for 4 cycles -> holds 32'hFFFFFFFF.
REQ-036 nRST pulse low during DWAIT -> stall_cnt=0 and halt_o=0 before next CLK edge; mem_dREN=0 afterwards gives RUN defaults.
